fpu_status_sequencer: RTL and testbench
=======================================

Name: fpu_status_sequencer

Overview:
Per-instruction controller that drives the FPU status word register's control inputs. It raises and drops busy around each FPU instruction and accumulates exception pulses from the execution unit. At completion it commits the accumulated exceptions and condition codes in a single cycle. It applies the control-word masks to decide whether an interrupt is raised, and stalls instruction issue until FCLEX when an unmasked exception is pending.

Parameters:
TIMEOUT_CYCLES, 1024, max EXEC cycles before a forced commit with invalid set
CNT_W, 11, width of the execution cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
instr_start  in  1  decoder pulse: FPU instruction begins
instr_ready  out  1  sequencer can accept instr_start (state IDLE)
instr_done  in  1  execution unit completion pulse
exc_in  in  7  raw exception pulses {SF,PE,UE,OE,ZE,DE,IE}, valid during EXEC
cc_in  in  4  condition codes {C3,C2,C1,C0}
cc_valid  in  1  cc_in valid this cycle (EXEC only)
ctrl_mask  in  6  control-word masks {PM,UM,OM,ZM,DM,IM}; 1 = masked
ctrl_iem  in  1  interrupt enable mask; 1 = interrupts disabled
sw_exc  in  6  current sticky flags from status word bits [5:0]
fclex  in  1  clear-exceptions request pulse
set_busy  out  1  to status word
clear_busy  out  1  to status word
cc_write  out  1  to status word
cc_out  out  4  {C3,C2,C1,C0} to status word
exc_out  out  7  {SF,PE,UE,OE,ZE,DE,IE} pulses to status word
clear_exceptions  out  1  to status word
int_req  out  1  FPU interrupt request, level
timeout  out  1  sticky: a timeout commit occurred; cleared by fclex

Behaviour:
- States: IDLE, EXEC, COMMIT, HOLD.
- Reset: state IDLE. All registered outputs, accumulators, counter and fclex_pend are 0. instr_ready=1 (decoded from IDLE).
- Reset asserted mid-instruction aborts the instruction with no commit.
- IDLE -> EXEC on instr_start.
  - Clears exc_acc, cc_acc, cc_seen and the counter.
  - set_busy pulses for exactly 1 cycle: the first EXEC cycle (start at cycle N -> set_busy at N+1).
- instr_start outside IDLE is ignored.
- EXEC:
  - exc_acc |= exc_in every cycle.
  - When exc_in[6] (SF) is set, exc_acc[0] (IE) is also set.
  - cc_valid latches cc_in into cc_acc and sets cc_seen; the last write wins.
  - The counter increments each cycle.
  - instr_done -> COMMIT. exc_in and cc_in on the done cycle are included.
  - If the counter reaches TIMEOUT_CYCLES-1 without instr_done -> COMMIT with IE forced into exc_acc and timeout set.
  - instr_done on the same cycle as the timeout is treated as a normal done: no timeout flag, no forced IE.
- COMMIT (1 cycle, done at M -> COMMIT at M+1):
  - exc_out=exc_acc, clear_busy=1, cc_write=cc_seen, cc_out=cc_acc. All are single-cycle registered pulses.
  - Next state is HOLD if (exc_acc[5:0] & ~ctrl_mask)!=0 and ctrl_iem=0; otherwise IDLE.
- HOLD: instr_ready=0. Exits to IDLE on fclex or a pending fclex.
- fclex handling:
  - In IDLE or HOLD: clear_exceptions pulses 1 cycle later and timeout clears.
  - In EXEC or COMMIT: sets fclex_pend. It is serviced on the first cycle after COMMIT, so clear_exceptions never coincides with exc_out.
- int_req (registered, 1-cycle latency) = ~ctrl_iem & |(sw_exc & ~ctrl_mask).
  - Recomputed every cycle, so it drops 1 cycle after sw_exc clears or the masks change.
- exc_out is always 0 outside COMMIT. set_busy and clear_busy are never high in the same cycle.
- Back-to-back operation: instr_start in the IDLE cycle right after COMMIT is accepted, giving a minimum of 3 cycles per instruction when done follows start immediately.
- The counter saturates and does not wrap; it is reloaded on each IDLE->EXEC transition.

Test Plan:
- Basic instruction: start at cycle 0, done at cycle 3, cc_valid with cc_in=4'b1001 at cycle 2 -> set_busy at 1; COMMIT at 4 with clear_busy=1, cc_write=1, cc_out=1001, exc_out=0; instr_ready=1 at 5.
- Masked exception: exc_in=7'b0100000 (PE) at cycle 2, ctrl_mask=6'h3F -> exc_out=0100000 at COMMIT, next state IDLE, int_req stays 0.
- Unmasked, iem=0: ZE pulsed with ctrl_mask=6'b111011 -> COMMIT exc_out=0000100, then HOLD with instr_ready=0; sw_exc=000100 -> int_req=1; instr_start ignored; fclex -> clear_exceptions pulse, IDLE; int_req drops after sw_exc clears.
- Stack fault: exc_in=1000000 -> exc_out=1000001. Repeat with ctrl_iem=1 -> no HOLD, int_req=0.
- Timeout: TIMEOUT_CYCLES=8, no done -> COMMIT on the 9th cycle after start with exc_out[0]=1 and timeout=1. Repeat with done on the timeout cycle -> timeout=0.
- fclex during EXEC, then reset_n low mid-EXEC in a second run -> first run: clear_exceptions only on the cycle after COMMIT. Second run: all outputs 0, instr_ready=1 immediately, no COMMIT pulses.

Source files
------------

// File: rtl/fpu_status_sequencer.sv
// fpu_status_sequencer: drives the FPU status word controls around each instruction.
// It accumulates exceptions during execution, commits them, and gates issue on unmasked faults.
module fpu_status_sequencer #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 11
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       instr_start,
   output logic       instr_ready,
   input  logic       instr_done,
   input  logic [6:0] exc_in,
   input  logic [3:0] cc_in,
   input  logic       cc_valid,
   input  logic [5:0] ctrl_mask,
   input  logic       ctrl_iem,
   input  logic [5:0] sw_exc,
   input  logic       fclex,
   output logic       set_busy,
   output logic       clear_busy,
   output logic       cc_write,
   output logic [3:0] cc_out,
   output logic [6:0] exc_out,
   output logic       clear_exceptions,
   output logic       int_req,
   output logic       timeout
);
   typedef enum logic [1:0] {IDLE, EXEC, COMMIT, HOLD} state_t;
   state_t state_q, state_d;
   logic [6:0] exc_acc_q, exc_acc_d, exc_out_q, exc_out_d;
   logic [3:0] cc_acc_q, cc_acc_d, cc_out_q, cc_out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic cc_seen_q, cc_seen_d, fclex_pend_q, fclex_pend_d;
   logic set_busy_q, set_busy_d, clear_busy_q, clear_busy_d, cc_write_q, cc_write_d;
   logic clear_exc_q, clear_exc_d, int_req_q, int_req_d, timeout_q, timeout_d;
   logic start, in_exec, to_hit, fin, svc;
   always_comb begin
      start        = state_q == IDLE && instr_start;
      in_exec      = state_q == EXEC;
      // a done arriving on the last allowed cycle wins over the timeout
      to_hit       = in_exec && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && !instr_done;
      fin          = in_exec && (instr_done || to_hit);
      svc          = state_q == COMMIT && (fclex || fclex_pend_q);
      exc_acc_d    = start ? '0 : in_exec ? exc_acc_q | exc_in | {6'b0, exc_in[6] | to_hit} : exc_acc_q;
      cc_acc_d     = start ? '0 : (in_exec && cc_valid) ? cc_in : cc_acc_q;
      cc_seen_d    = start ? 1'b0 : cc_seen_q | (in_exec && cc_valid);
      cnt_d        = start ? '0 : (in_exec && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
      fclex_pend_d = (in_exec && fclex) ? 1'b1 : state_q == COMMIT ? 1'b0 : fclex_pend_q;
      clear_exc_d  = svc || (fclex && (state_q == IDLE || state_q == HOLD));
      timeout_d    = to_hit ? 1'b1 : clear_exc_d ? 1'b0 : timeout_q;
      set_busy_d   = start;
      clear_busy_d = fin;
      cc_write_d   = fin && cc_seen_d;
      cc_out_d     = fin ? cc_acc_d : '0;
      exc_out_d    = fin ? exc_acc_d : '0;
      int_req_d    = !ctrl_iem && |(sw_exc & ~ctrl_mask);
      unique case (state_q)
         IDLE:    state_d = instr_start ? EXEC : IDLE;
         EXEC:    state_d = fin ? COMMIT : EXEC;
         COMMIT:  state_d = (|(exc_acc_q[5:0] & ~ctrl_mask) && !ctrl_iem && !svc) ? HOLD : IDLE;
         default: state_d = (fclex || fclex_pend_q) ? IDLE : HOLD;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         exc_acc_q    <= '0;
         cc_acc_q     <= '0;
         cc_seen_q    <= 1'b0;
         cnt_q        <= '0;
         fclex_pend_q <= 1'b0;
         set_busy_q   <= 1'b0;
         clear_busy_q <= 1'b0;
         cc_write_q   <= 1'b0;
         cc_out_q     <= '0;
         exc_out_q    <= '0;
         clear_exc_q  <= 1'b0;
         int_req_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         exc_acc_q    <= exc_acc_d;
         cc_acc_q     <= cc_acc_d;
         cc_seen_q    <= cc_seen_d;
         cnt_q        <= cnt_d;
         fclex_pend_q <= fclex_pend_d;
         set_busy_q   <= set_busy_d;
         clear_busy_q <= clear_busy_d;
         cc_write_q   <= cc_write_d;
         cc_out_q     <= cc_out_d;
         exc_out_q    <= exc_out_d;
         clear_exc_q  <= clear_exc_d;
         int_req_q    <= int_req_d;
         timeout_q    <= timeout_d;
      end
   end
   assign instr_ready      = state_q == IDLE;
   assign set_busy         = set_busy_q;
   assign clear_busy       = clear_busy_q;
   assign cc_write         = cc_write_q;
   assign cc_out           = cc_out_q;
   assign exc_out          = exc_out_q;
   assign clear_exceptions = clear_exc_q;
   assign int_req          = int_req_q;
   assign timeout          = timeout_q;
endmodule

// File: tb/tb_fpu_status_sequencer.sv
// tb_fpu_status_sequencer: directed steps with hand-computed expectations.
module tb_fpu_status_sequencer;
   logic clk = 1'b0, reset_n = 1'b0;
   logic instr_start = 0, instr_done = 0, cc_valid = 0, ctrl_iem = 0, fclex = 0;
   logic [6:0] exc_in = '0;
   logic [3:0] cc_in = '0;
   logic [5:0] ctrl_mask = 6'h3F, sw_exc = '0;
   logic instr_ready, set_busy, clear_busy, cc_write, clear_exceptions, int_req, timeout;
   logic [3:0] cc_out;
   logic [6:0] exc_out;
   int checks = 0, failures = 0;
   fpu_status_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .instr_start(instr_start), .instr_ready(instr_ready),
      .instr_done(instr_done), .exc_in(exc_in), .cc_in(cc_in), .cc_valid(cc_valid),
      .ctrl_mask(ctrl_mask), .ctrl_iem(ctrl_iem), .sw_exc(sw_exc), .fclex(fclex),
      .set_busy(set_busy), .clear_busy(clear_busy), .cc_write(cc_write), .cc_out(cc_out),
      .exc_out(exc_out), .clear_exceptions(clear_exceptions), .int_req(int_req), .timeout(timeout)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      #1;
      chk("rst_ready", 32'(instr_ready), 1);
      chk("rst_set_busy", 32'(set_busy), 0);
      chk("rst_exc_out", 32'(exc_out), 0);
      chk("rst_timeout", 32'(timeout), 0);
      step(); step();
      reset_n = 1'b1;
      step();
      // basic instruction
      instr_start = 1; step();
      instr_start = 0;
      chk("b_set_busy1", 32'(set_busy), 1);
      chk("b_ready1", 32'(instr_ready), 0);
      step();
      chk("b_set_busy2", 32'(set_busy), 0);
      cc_valid = 1; cc_in = 4'b1001; step();
      cc_valid = 0; cc_in = 0; instr_done = 1; step();
      instr_done = 0;
      chk("b_clear_busy", 32'(clear_busy), 1);
      chk("b_cc_write", 32'(cc_write), 1);
      chk("b_cc_out", 32'(cc_out), 4'b1001);
      chk("b_exc_out", 32'(exc_out), 0);
      chk("b_set_busy4", 32'(set_busy), 0);
      step();
      chk("b_ready5", 32'(instr_ready), 1);
      chk("b_clear_busy5", 32'(clear_busy), 0);
      // masked precision exception
      instr_start = 1; step();
      instr_start = 0; step();
      exc_in = 7'b0100000; step();
      exc_in = 0; instr_done = 1; step();
      instr_done = 0;
      chk("m_exc_out", 32'(exc_out), 7'b0100000);
      chk("m_cc_write", 32'(cc_write), 0);
      step();
      chk("m_ready", 32'(instr_ready), 1);
      chk("m_int_req", 32'(int_req), 0);
      // unmasked zero-divide with interrupts enabled
      ctrl_mask = 6'b111011;
      instr_start = 1; step();
      instr_start = 0; exc_in = 7'b0000100; instr_done = 1; step();
      exc_in = 0; instr_done = 0;
      chk("u_exc_out", 32'(exc_out), 7'b0000100);
      sw_exc = 6'b000100; step();
      chk("u_hold_ready", 32'(instr_ready), 0);
      chk("u_int_req", 32'(int_req), 1);
      instr_start = 1; step();
      instr_start = 0;
      chk("u_start_ignored", 32'(set_busy), 0);
      chk("u_still_hold", 32'(instr_ready), 0);
      fclex = 1; step();
      fclex = 0;
      chk("u_clear_exc", 32'(clear_exceptions), 1);
      chk("u_idle", 32'(instr_ready), 1);
      sw_exc = 0; step();
      chk("u_clear_exc_off", 32'(clear_exceptions), 0);
      chk("u_int_drop", 32'(int_req), 0);
      // stack fault forces IE; first with IE unmasked
      ctrl_mask = 6'h3E;
      instr_start = 1; step();
      instr_start = 0; exc_in = 7'b1000000; instr_done = 1; step();
      exc_in = 0; instr_done = 0;
      chk("s_exc_out", 32'(exc_out), 7'b1000001);
      step();
      chk("s_hold", 32'(instr_ready), 0);
      fclex = 1; step();
      fclex = 0;
      chk("s_release", 32'(instr_ready), 1);
      ctrl_iem = 1; sw_exc = 6'h01;
      instr_start = 1; step();
      instr_start = 0; exc_in = 7'b1000000; instr_done = 1; step();
      exc_in = 0; instr_done = 0;
      chk("s_iem_exc_out", 32'(exc_out), 7'b1000001);
      step();
      chk("s_iem_no_hold", 32'(instr_ready), 1);
      chk("s_iem_int_req", 32'(int_req), 0);
      ctrl_iem = 0; sw_exc = 0; ctrl_mask = 6'h3F;
      // timeout after 8 execution cycles
      instr_start = 1; step();
      instr_start = 0;
      for (int i = 0; i < 7; i++) step();
      chk("t_still_exec", 32'(clear_busy), 0);
      step();
      chk("t_exc_out", 32'(exc_out), 7'b0000001);
      chk("t_timeout", 32'(timeout), 1);
      chk("t_clear_busy", 32'(clear_busy), 1);
      step();
      chk("t_ready", 32'(instr_ready), 1);
      chk("t_sticky", 32'(timeout), 1);
      fclex = 1; step();
      fclex = 0;
      chk("t_cleared", 32'(timeout), 0);
      chk("t_clear_exc", 32'(clear_exceptions), 1);
      // done on the timeout cycle is a normal completion
      instr_start = 1; step();
      instr_start = 0;
      for (int i = 0; i < 7; i++) step();
      instr_done = 1; step();
      instr_done = 0;
      chk("td_exc_out", 32'(exc_out), 0);
      chk("td_timeout", 32'(timeout), 0);
      chk("td_clear_busy", 32'(clear_busy), 1);
      step();
      // fclex during EXEC is deferred past COMMIT
      instr_start = 1; step();
      instr_start = 0; fclex = 1; step();
      fclex = 0;
      chk("f_no_early_clear", 32'(clear_exceptions), 0);
      exc_in = 7'b0100000; instr_done = 1; step();
      exc_in = 0; instr_done = 0;
      chk("f_exc_out", 32'(exc_out), 7'b0100000);
      chk("f_not_with_commit", 32'(clear_exceptions), 0);
      step();
      chk("f_clear_after", 32'(clear_exceptions), 1);
      chk("f_exc_out_off", 32'(exc_out), 0);
      step();
      chk("f_clear_once", 32'(clear_exceptions), 0);
      // reset mid-EXEC aborts without commit
      instr_start = 1; step();
      instr_start = 0; exc_in = 7'b0000100; cc_valid = 1; cc_in = 4'hF; step();
      exc_in = 0; cc_valid = 0; cc_in = 0;
      reset_n = 0; #1;
      chk("r_ready", 32'(instr_ready), 1);
      chk("r_exc_out", 32'(exc_out), 0);
      chk("r_set_busy", 32'(set_busy), 0);
      step();
      reset_n = 1; instr_done = 1; step();
      instr_done = 0;
      chk("r_no_clear_busy", 32'(clear_busy), 0);
      chk("r_no_cc_write", 32'(cc_write), 0);
      chk("r_no_exc_out", 32'(exc_out), 0);
      chk("r_idle", 32'(instr_ready), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
